// File: rtl/cmd_proc_pkg.sv
// Shared types and opcode constants for the command processor.
package cmd_proc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    WAIT1,
    SEND2,
    WAIT2
  } state_t;

  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_READ  = 4'h2;
  localparam logic [7:0] OP_CLEAR = 8'h30;

  function automatic logic idx_ok(input logic [3:0] idx, input int unsigned num_regs);
    return {28'd0, idx} < num_regs;
  endfunction

endpackage

// File: rtl/cmd_wdog.sv
// Idle watchdog: counts cycles since the last kick and pulses trip at the all-ones count.
module cmd_wdog #(
  parameter int unsigned WDOG_W = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic kick,
  output logic trip
);

  localparam logic [WDOG_W-1:0] CNT_MAX = '1;

  logic [WDOG_W-1:0] cnt_q, cnt_d;

  // A kick landing on the expiry cycle suppresses the trip.
  assign trip = (cnt_q == CNT_MAX) && !kick;

  always_comb begin
    cnt_d = cnt_q + {{(WDOG_W-1){1'b0}}, 1'b1};
    if (kick || trip) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cmd_proc.sv
// Command processor: executes UART commands on a small config register file and returns
// ACK/NAK/read bytes. Define CMD_PROC_WDOG_EN to include the idle watchdog.
module cmd_proc
  import cmd_proc_pkg::*;
#(
  parameter int unsigned NUM_REGS = 4,
  parameter logic [7:0]  ACK      = 8'hA5,
  parameter logic [7:0]  NAK      = 8'hEE,
  parameter int unsigned WDOG_W   = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_rdy,
  input  logic [7:0]               cmd,
  input  logic [15:0]              data,
  output logic                     clr_cmd_rdy,
  output logic                     snd_resp,
  output logic [7:0]               resp,
  input  logic                     resp_sent,
  output logic [16*NUM_REGS-1:0]   cfg_regs,
  output logic [NUM_REGS-1:0]      cfg_wr,
  output logic                     wdog_trip,
  output state_t                   state_dbg
);

  state_t                       state_q, state_d;
  logic [7:0]                   cmd_q, cmd_d;
  logic [15:0]                  data_q, data_d;
  logic [7:0]                   resp_q, resp_d;
  logic [7:0]                   rd_lo_q, rd_lo_d;
  logic                         second_q, second_d;
  logic                         snd_resp_q, snd_resp_d;
  logic [NUM_REGS-1:0]          cfg_wr_q, cfg_wr_d;
  logic [NUM_REGS-1:0][15:0]    regs_q, regs_d;

  logic        accept;
  logic        wdog_hit;
  logic [3:0]  idx;
  logic [15:0] rd_word;
  logic        in_range, is_write, is_read, is_clear;

  assign accept = (state_q == IDLE) && cmd_rdy;
  assign idx    = cmd[3:0];

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == 4'(i)) rd_word = regs_q[i];
    end
    in_range = idx_ok(idx, NUM_REGS);
    is_write = (cmd[7:4] == OP_WRITE) && in_range;
    is_read  = (cmd[7:4] == OP_READ) && in_range;
    is_clear = (cmd == OP_CLEAR);
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    data_d     = data_q;
    resp_d     = resp_q;
    rd_lo_d    = rd_lo_q;
    second_d   = second_q;
    snd_resp_d = 1'b0;
    cfg_wr_d   = '0;
    regs_d     = regs_q;

    // cfg_wr_q is only non-zero during EXEC, so it doubles as the write enable.
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cfg_wr_q[i]) regs_d[i] = (cmd_q == OP_CLEAR) ? 16'h0000 : data_q;
    end
    if (wdog_hit) regs_d = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          cmd_d      = cmd;
          data_d     = data;
          state_d    = EXEC;
          snd_resp_d = 1'b1;
          second_d   = is_read;
          rd_lo_d    = rd_word[7:0];
          if (is_read)                resp_d = rd_word[15:8];
          else if (is_write || is_clear) resp_d = ACK;
          else                        resp_d = NAK;
          if (is_clear) cfg_wr_d = '1;
          else begin
            for (int i = 0; i < NUM_REGS; i++) cfg_wr_d[i] = is_write && (idx == 4'(i));
          end
        end
      end
      EXEC: state_d = WAIT1;
      WAIT1: begin
        if (resp_sent) begin
          if (second_q) begin
            state_d    = SEND2;
            resp_d     = rd_lo_q;
            snd_resp_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      SEND2: state_d = WAIT2;
      WAIT2: if (resp_sent) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      data_q     <= '0;
      resp_q     <= '0;
      rd_lo_q    <= '0;
      second_q   <= 1'b0;
      snd_resp_q <= 1'b0;
      cfg_wr_q   <= '0;
      regs_q     <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      data_q     <= data_d;
      resp_q     <= resp_d;
      rd_lo_q    <= rd_lo_d;
      second_q   <= second_d;
      snd_resp_q <= snd_resp_d;
      cfg_wr_q   <= cfg_wr_d;
      regs_q     <= regs_d;
    end
  end

`ifdef CMD_PROC_WDOG_EN
  cmd_wdog #(.WDOG_W(WDOG_W)) u_wdog (
    .clk   (clk),
    .rst_n (rst_n),
    .kick  (accept),
    .trip  (wdog_hit)
  );
`else
  assign wdog_hit = 1'b0;
`endif

  assign clr_cmd_rdy = accept;
  assign snd_resp    = snd_resp_q;
  assign resp        = resp_q;
  assign cfg_regs    = regs_q;
  assign cfg_wr      = cfg_wr_q | {NUM_REGS{wdog_hit}};
  assign wdog_trip   = wdog_hit;
  assign state_dbg   = state_q;

endmodule
